// File: rtl/cam_capture_rx.sv
// Camera parallel-port receiver: pairs RGB565 bytes into pixels, tags x/y/address,
// and flags line-length and line-count timing errors.
module cam_capture_rx #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned ADDR_W   = 19
) (
  input  logic              PCLK,
  input  logic              reset,
  input  logic              capture_en,
  input  logic              clr_err,
  input  logic              VSYNC,
  input  logic              HREF,
  input  logic [7:0]        DATA,
  output logic              pix_valid,
  output logic [15:0]       pix_data,
  output logic [9:0]        pix_x,
  output logic [8:0]        pix_y,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              frame_start,
  output logic              frame_end,
  output logic              busy,
  output logic              err_hlen,
  output logic              err_vcnt,
  output logic [15:0]       frame_cnt
);

  localparam int unsigned LineBytes = 2 * H_ACTIVE;
  localparam int unsigned BcntW     = $clog2(LineBytes + 1);

  typedef enum logic [1:0] {StIdle, StWaitVs, StVblank, StFrame} state_e;

  // Pin capture stage plus one extra delay for edge detection; free-running so
  // that edges are judged against the true pin history even across a reset.
  logic       vs_q, vs_qq, hr_q, hr_qq;
  logic [7:0] d_q;

  always_ff @(posedge PCLK) begin
    vs_q  <= VSYNC;
    vs_qq <= vs_q;
    hr_q  <= HREF;
    hr_qq <= hr_q;
    d_q   <= DATA;
  end

  state_e            state_q;
  logic [BcntW-1:0]  bcnt_q;
  logic [7:0]        hi_q;
  logic [9:0]        x_q;
  logic [8:0]        y_q;
  logic [ADDR_W-1:0] addr_q, row_base_q;
  logic              line_pix_q, frame_err_q, extra_chk_q;

  logic vs_rise, hr_rise, hr_fall;
  logic enter_frame, frame_abort, clr_cnt, byte_take, overflow;
  logic line_end, line_bad, last_line, hlen_set, vcnt_set;
  logic err_hlen_d, err_vcnt_d;

  always_comb begin
    vs_rise     = vs_q & ~vs_qq;
    hr_rise     = hr_q & ~hr_qq;
    hr_fall     = ~hr_q & hr_qq;
    enter_frame = (state_q == StVblank) && hr_rise && !vs_q;
    frame_abort = (state_q == StFrame) && vs_rise;
    clr_cnt     = (state_q == StVblank) || ((state_q == StWaitVs) && vs_rise) || frame_abort;
    byte_take   = hr_q && (((state_q == StFrame) && !vs_rise) || enter_frame);
    overflow    = byte_take && (bcnt_q >= BcntW'(LineBytes));
    line_end    = (state_q == StFrame) && !vs_rise && hr_fall;
    line_bad    = line_end && (bcnt_q != BcntW'(LineBytes));
    last_line   = line_end && line_pix_q && (y_q == 9'(V_ACTIVE - 1));
    hlen_set    = overflow | line_bad;
    // Extra lines only count after a completed frame, not after reset or a skipped frame.
    vcnt_set    = frame_abort | ((state_q == StWaitVs) && extra_chk_q && hr_rise);
    err_hlen_d  = hlen_set | (err_hlen & ~clr_err);
    err_vcnt_d  = vcnt_set | (err_vcnt & ~clr_err);
  end

  always_ff @(posedge PCLK) begin
    if (reset) begin
      state_q     <= StIdle;
      bcnt_q      <= '0;
      hi_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      addr_q      <= '0;
      row_base_q  <= '0;
      line_pix_q  <= 1'b0;
      frame_err_q <= 1'b0;
      extra_chk_q <= 1'b0;
      pix_valid   <= 1'b0;
      pix_data    <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_addr    <= '0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      err_hlen    <= 1'b0;
      err_vcnt    <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      err_hlen    <= err_hlen_d;
      err_vcnt    <= err_vcnt_d;

      if (clr_cnt) begin
        bcnt_q      <= '0;
        x_q         <= '0;
        y_q         <= '0;
        addr_q      <= '0;
        row_base_q  <= '0;
        line_pix_q  <= 1'b0;
        frame_err_q <= 1'b0;
      end

      case (state_q)
        StIdle: state_q <= StWaitVs;
        StWaitVs: begin
          if (vs_rise) begin
            extra_chk_q <= 1'b0;
            if (capture_en) state_q <= StVblank;
          end
        end
        StVblank: begin
          if (enter_frame) state_q <= StFrame;
        end
        StFrame: begin
          if (vs_rise) begin
            state_q <= capture_en ? StVblank : StWaitVs;
          end else if (hr_fall) begin
            bcnt_q     <= '0;
            x_q        <= '0;
            line_pix_q <= 1'b0;
            if (line_pix_q) begin
              // Re-align to the row base so a short line cannot skew later addresses.
              y_q        <= y_q + 9'd1;
              row_base_q <= row_base_q + ADDR_W'(H_ACTIVE);
              addr_q     <= row_base_q + ADDR_W'(H_ACTIVE);
            end
            if (last_line) begin
              state_q     <= StWaitVs;
              extra_chk_q <= 1'b1;
              if (!frame_err_q && !line_bad) frame_cnt <= frame_cnt + 16'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase

      // Placed after the counter clear so the first byte of a frame is not lost.
      if (byte_take && !overflow) begin
        bcnt_q <= bcnt_q + 1'b1;
        if (!bcnt_q[0]) begin
          hi_q <= d_q;
        end else begin
          pix_valid   <= 1'b1;
          pix_data    <= {hi_q, d_q};
          pix_x       <= x_q;
          pix_y       <= y_q;
          pix_addr    <= addr_q;
          frame_start <= (x_q == '0) && (y_q == '0);
          frame_end   <= (x_q == 10'(H_ACTIVE - 1)) && (y_q == 9'(V_ACTIVE - 1));
          x_q         <= x_q + 10'd1;
          addr_q      <= addr_q + ADDR_W'(1);
          line_pix_q  <= 1'b1;
        end
      end
      if (hlen_set) frame_err_q <= 1'b1;
    end
  end

  assign busy = (state_q == StFrame);

endmodule
